// File: rtl/locked_reg_bank_arbiter_if.sv
// Requester-side bus of the locked register bank arbiter.
// The master side (host/debug requesters) drives requests, the slave side answers.
interface locked_reg_bank_arbiter_if #(
   parameter int AW = 2,
   parameter int DW = 16
);
   logic [1:0]    req;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata0;
   logic [DW-1:0] wdata1;
   logic          lock0;
   logic          lock1;
   logic          trusted;
   logic          debug_mode;
   logic [1:0]    gnt;
   logic [1:0]    ack;
   logic          err;

   modport master (
      output req, addr0, addr1, wdata0, wdata1,
      output lock0, lock1, trusted, debug_mode,
      input  gnt, ack, err
   );

   modport slave (
      input  req, addr0, addr1, wdata0, wdata1,
      input  lock0, lock1, trusted, debug_mode,
      output gnt, ack, err
   );
endinterface

// File: rtl/locked_reg_bank_arbiter.sv
// Two-requester round-robin arbiter owning a bank of sticky-lockable registers.
// Optional LOCK_VIOLATION_LOG_EN adds a counter/log of rejected locked writes.
module locked_reg_bank_arbiter #(
   parameter int NUM_REGS = 4,
   parameter int AW       = 2,
   parameter int DW       = 16
) (
   input  logic                   Clk,
   input  logic                   resetn,
   locked_reg_bank_arbiter_if.slave bus,
   output logic [NUM_REGS*DW-1:0] reg_q,
   output logic [NUM_REGS-1:0]    lock_q
`ifdef LOCK_VIOLATION_LOG_EN
   ,
   output logic [7:0]             viol_count,
   output logic [AW-1:0]          viol_addr
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      EXEC,
      RESP
   } state_t;

   state_t        state;
   state_t        state_n;
   logic          sel;
   logic          sel_n;
   logic          rr;
   logic [AW-1:0] op_addr;
   logic [DW-1:0] op_wdata;
   logic          op_lock;
   logic          err_q;
   logic          in_range;
   logic          cur_lock;
   logic          wr_ok;
   logic          op_err;
   logic [1:0]    gnt_c;
   logic [1:0]    ack_c;
   logic          err_c;

   assign bus.gnt = gnt_c;
   assign bus.ack = ack_c;
   assign bus.err = err_c;

   always_ff @(posedge Clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      sel_n   = sel;
      gnt_c   = 2'b00;
      ack_c   = 2'b00;
      err_c   = 1'b0;
      unique case (state)
         IDLE: begin
            if (|bus.req) begin
               state_n = GRANT;
               // contention goes to the pointer, a lone request wins outright
               sel_n   = (&bus.req) ? rr : bus.req[1];
            end
         end
         GRANT: begin
            gnt_c   = {sel, ~sel};
            state_n = EXEC;
         end
         EXEC: begin
            state_n = RESP;
         end
         RESP: begin
            ack_c   = {sel, ~sel};
            err_c   = err_q;
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_comb begin
      in_range = ({1'b0, op_addr} < (AW+1)'(NUM_REGS));
      cur_lock = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (op_addr == AW'(i)) begin
            cur_lock = lock_q[i];
         end
      end
      // only a trusted debug agent in debug mode may override a lock
      wr_ok  = !cur_lock || (sel && bus.trusted && bus.debug_mode);
      op_err = !in_range || (!op_lock && !wr_ok);
   end

   always_ff @(posedge Clk or negedge resetn) begin
      if (!resetn) begin
         sel      <= 1'b0;
         rr       <= 1'b0;
         op_addr  <= '0;
         op_wdata <= '0;
         op_lock  <= 1'b0;
         err_q    <= 1'b0;
         reg_q    <= '0;
         lock_q   <= '0;
      end else begin
         sel <= sel_n;
         if (state == GRANT) begin
            op_addr  <= sel ? bus.addr1  : bus.addr0;
            op_wdata <= sel ? bus.wdata1 : bus.wdata0;
            op_lock  <= sel ? bus.lock1  : bus.lock0;
            rr       <= ~sel;
         end
         if (state == EXEC) begin
            err_q <= op_err;
            if (in_range) begin
               for (int i = 0; i < NUM_REGS; i++) begin
                  if (op_addr == AW'(i)) begin
                     if (op_lock) begin
                        lock_q[i] <= 1'b1;
                     end else if (wr_ok) begin
                        reg_q[i*DW +: DW] <= op_wdata;
                     end
                  end
               end
            end
         end
      end
   end

`ifdef LOCK_VIOLATION_LOG_EN
   logic viol;

   assign viol = in_range && !op_lock && !wr_ok;

   // count never returns to zero, so zero marks "no violation captured yet"
   always_ff @(posedge Clk or negedge resetn) begin
      if (!resetn) begin
         viol_count <= '0;
         viol_addr  <= '0;
      end else if (state == EXEC && viol) begin
         if (viol_count != 8'hFF) begin
            viol_count <= viol_count + 8'd1;
         end
         if (viol_count == 8'd0) begin
            viol_addr <= op_addr;
         end
      end
   end
`endif

endmodule

// File: tb/tb_locked_reg_bank_arbiter.sv
// Self-checking bench for locked_reg_bank_arbiter.
// Scenario tasks compare the DUT against a queue-free array model of the bank.
module tb_locked_reg_bank_arbiter;
   localparam int NR = 4;
   localparam int AW = 2;
   localparam int DW = 16;

   logic Clk = 1'b0;
   logic resetn;
   always #5 Clk = ~Clk;

   locked_reg_bank_arbiter_if #(.AW(AW), .DW(DW)) bus_if ();

   logic [NR*DW-1:0] reg_q;
   logic [NR-1:0]    lock_q;
`ifdef LOCK_VIOLATION_LOG_EN
   logic [7:0]       viol_count;
   logic [AW-1:0]    viol_addr;
`endif

   locked_reg_bank_arbiter #(.NUM_REGS(NR), .AW(AW), .DW(DW)) dut (
      .Clk    (Clk),
      .resetn (resetn),
      .bus    (bus_if),
      .reg_q  (reg_q),
      .lock_q (lock_q)
`ifdef LOCK_VIOLATION_LOG_EN
      ,
      .viol_count (viol_count),
      .viol_addr  (viol_addr)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [DW-1:0] m_regs [NR];
   bit            m_lock [NR];
   bit            m_rr;
   int            m_viol;
   bit            m_vseen;
   logic [AW-1:0] m_vaddr;

   function automatic void model_reset();
      for (int i = 0; i < NR; i++) begin
         m_regs[i] = '0;
         m_lock[i] = 1'b0;
      end
      m_rr    = 1'b0;
      m_viol  = 0;
      m_vseen = 1'b0;
      m_vaddr = '0;
   endfunction

   function automatic bit model_exec(bit r, logic [AW-1:0] a,
                                     logic [DW-1:0] d, bit lk,
                                     bit tr, bit dm);
      if (int'(a) >= NR) return 1'b1;
      if (lk) begin
         m_lock[a] = 1'b1;
         return 1'b0;
      end
      if (!m_lock[a] || (r && tr && dm)) begin
         m_regs[a] = d;
         return 1'b0;
      end
      if (m_viol < 255) m_viol++;
      if (!m_vseen) begin
         m_vseen = 1'b1;
         m_vaddr = a;
      end
      return 1'b1;
   endfunction

   function automatic logic [NR*DW-1:0] m_regq();
      logic [NR*DW-1:0] v;
      for (int i = 0; i < NR; i++) v[i*DW +: DW] = m_regs[i];
      return v;
   endfunction

   function automatic logic [NR-1:0] m_lockq();
      logic [NR-1:0] v;
      for (int i = 0; i < NR; i++) v[i] = m_lock[i];
      return v;
   endfunction

   task automatic do_reset();
      resetn      = 1'b0;
      bus_if.req  = 2'b00;
      model_reset();
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      resetn = 1'b1;
      @(posedge Clk);
      #1;
   endtask

   // Issues rq from IDLE and walks GRANT/EXEC/RESP/IDLE checking each phase.
   task automatic run_access(string name, logic [1:0] rq, bit hold);
      bit            s;
      bit            e;
      logic [1:0]    oh;
      s  = (rq == 2'b11) ? m_rr : rq[1];
      oh = s ? 2'b10 : 2'b01;
      bus_if.req = rq;
      @(posedge Clk); #1;
      n_cmp++;
      if (bus_if.gnt !== oh || bus_if.ack !== 2'b00) begin
         n_bad++;
         $display("FAIL %s grant: gnt=%b ack=%b required gnt=%b ack=00",
                  name, bus_if.gnt, bus_if.ack, oh);
      end
      @(posedge Clk); #1;
      n_cmp++;
      if (bus_if.gnt !== 2'b00 || bus_if.ack !== 2'b00 ||
          bus_if.err !== 1'b0) begin
         n_bad++;
         $display("FAIL %s exec: gnt=%b ack=%b err=%b required 00/00/0",
                  name, bus_if.gnt, bus_if.ack, bus_if.err);
      end
      m_rr = ~s;
      e = model_exec(s, s ? bus_if.addr1 : bus_if.addr0,
                     s ? bus_if.wdata1 : bus_if.wdata0,
                     s ? bus_if.lock1 : bus_if.lock0,
                     bus_if.trusted, bus_if.debug_mode);
      @(posedge Clk); #1;
      n_cmp++;
      if (bus_if.ack !== oh || bus_if.err !== e || bus_if.gnt !== 2'b00) begin
         n_bad++;
         $display("FAIL %s resp: ack=%b err=%b required ack=%b err=%b",
                  name, bus_if.ack, bus_if.err, oh, e);
      end
      n_cmp++;
      if (reg_q !== m_regq() || lock_q !== m_lockq()) begin
         n_bad++;
         $display("FAIL %s bank: reg_q=%h lock_q=%b required %h %b",
                  name, reg_q, lock_q, m_regq(), m_lockq());
      end
`ifdef LOCK_VIOLATION_LOG_EN
      n_cmp++;
      if (viol_count !== 8'(m_viol) || viol_addr !== m_vaddr) begin
         n_bad++;
         $display("FAIL %s viol: count=%0d addr=%0d required %0d %0d",
                  name, viol_count, viol_addr, m_viol, m_vaddr);
      end
`endif
      if (!hold) bus_if.req = 2'b00;
      @(posedge Clk); #1;
      n_cmp++;
      if (bus_if.ack !== 2'b00 || bus_if.err !== 1'b0) begin
         n_bad++;
         $display("FAIL %s idle: ack=%b err=%b required 00 0",
                  name, bus_if.ack, bus_if.err);
      end
   endtask

   task automatic set_host(logic [AW-1:0] a, logic [DW-1:0] d, bit lk);
      bus_if.addr0  = a;
      bus_if.wdata0 = d;
      bus_if.lock0  = lk;
   endtask

   task automatic set_dbg(logic [AW-1:0] a, logic [DW-1:0] d, bit lk);
      bus_if.addr1  = a;
      bus_if.wdata1 = d;
      bus_if.lock1  = lk;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (bus_if.gnt !== 2'b00 || bus_if.ack !== 2'b00 ||
          bus_if.err !== 1'b0 || reg_q !== '0 || lock_q !== '0) begin
         n_bad++;
         $display("FAIL reset: gnt=%b ack=%b err=%b reg_q=%h lock_q=%b required zeros",
                  bus_if.gnt, bus_if.ack, bus_if.err, reg_q, lock_q);
      end
   endtask

   task automatic test_host_write();
      set_host(2'd1, 16'hA5A5, 1'b0);
      run_access("host_write", 2'b01, 1'b0);
      n_cmp++;
      if (reg_q[31:16] !== 16'hA5A5) begin
         n_bad++;
         $display("FAIL host_write_reg1: got %h required a5a5", reg_q[31:16]);
      end
   endtask

   task automatic test_lock();
      set_host(2'd1, 16'h0000, 1'b1);
      run_access("host_lock", 2'b01, 1'b0);
      set_host(2'd1, 16'h1234, 1'b0);
      run_access("locked_write", 2'b01, 1'b0);
      n_cmp++;
      if (lock_q[1] !== 1'b1 || reg_q[31:16] !== 16'hA5A5) begin
         n_bad++;
         $display("FAIL lock_hold: lock1=%b reg1=%h required 1 a5a5",
                  lock_q[1], reg_q[31:16]);
      end
      set_host(2'd1, 16'h0000, 1'b1);
      run_access("relock", 2'b01, 1'b0);
   endtask

   task automatic test_trusted_debug();
      bus_if.trusted    = 1'b1;
      bus_if.debug_mode = 1'b1;
      set_dbg(2'd1, 16'hBEEF, 1'b0);
      run_access("trusted_write", 2'b10, 1'b0);
      bus_if.debug_mode = 1'b0;
      set_dbg(2'd1, 16'h5555, 1'b0);
      run_access("no_dbg_write", 2'b10, 1'b0);
      n_cmp++;
      if (reg_q[31:16] !== 16'hBEEF) begin
         n_bad++;
         $display("FAIL debug_reg1: got %h required beef", reg_q[31:16]);
      end
      bus_if.trusted = 1'b0;
   endtask

   task automatic test_alternation();
      do_reset();
      set_host(2'd0, 16'h1111, 1'b0);
      set_dbg(2'd2, 16'h2222, 1'b0);
      for (int k = 0; k < 4; k++) begin
         run_access("alternate", 2'b11, k != 3);
      end
   endtask

   task automatic test_reset_mid();
      set_host(2'd2, 16'h7777, 1'b0);
      bus_if.req = 2'b01;
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      resetn     = 1'b0;
      bus_if.req = 2'b00;
      model_reset();
      #1;
      n_cmp++;
      if (bus_if.gnt !== 2'b00 || bus_if.ack !== 2'b00 ||
          reg_q !== '0 || lock_q !== '0) begin
         n_bad++;
         $display("FAIL reset_mid: gnt=%b ack=%b reg_q=%h lock_q=%b required zeros",
                  bus_if.gnt, bus_if.ack, reg_q, lock_q);
      end
      for (int k = 0; k < 3; k++) begin
         @(posedge Clk); #1;
         n_cmp++;
         if (bus_if.ack !== 2'b00 || reg_q !== '0) begin
            n_bad++;
            $display("FAIL reset_hold: ack=%b reg_q=%h required 00 0",
                     bus_if.ack, reg_q);
         end
      end
      @(negedge Clk);
      resetn = 1'b1;
      @(posedge Clk); #1;
      set_host(2'd2, 16'h4242, 1'b0);
      run_access("after_reset", 2'b01, 1'b0);
   endtask

   task automatic test_random();
      for (int k = 0; k < 60; k++) begin
         set_host(AW'($urandom), DW'($urandom), ($urandom % 6) == 0);
         set_dbg(AW'($urandom), DW'($urandom), ($urandom % 6) == 0);
         bus_if.trusted    = 1'($urandom);
         bus_if.debug_mode = 1'($urandom);
         run_access("random", 2'($urandom_range(1, 3)), 1'b0);
      end
   endtask

`ifdef LOCK_VIOLATION_LOG_EN
   task automatic test_viol_log();
      do_reset();
      bus_if.trusted    = 1'b0;
      bus_if.debug_mode = 1'b0;
      set_host(2'd3, 16'h0, 1'b1);
      run_access("vl_lock3", 2'b01, 1'b0);
      for (int k = 0; k < 3; k++) begin
         set_host(2'd3, DW'($urandom), 1'b0);
         run_access("vl_write3", 2'b01, 1'b0);
      end
      set_host(2'd1, 16'h0, 1'b1);
      run_access("vl_lock1", 2'b01, 1'b0);
      set_host(2'd1, 16'h9999, 1'b0);
      run_access("vl_write1", 2'b01, 1'b0);
      n_cmp++;
      if (viol_count !== 8'd4 || viol_addr !== 2'd3) begin
         n_bad++;
         $display("FAIL viol_log: count=%0d addr=%0d required 4 3",
                  viol_count, viol_addr);
      end
   endtask
`endif

   initial begin
      resetn            = 1'b0;
      bus_if.req        = 2'b00;
      bus_if.trusted    = 1'b0;
      bus_if.debug_mode = 1'b0;
      set_host('0, '0, 1'b0);
      set_dbg('0, '0, 1'b0);
      model_reset();
      test_reset();
      test_host_write();
      test_lock();
      test_trusted_debug();
      test_alternation();
      test_reset_mid();
      test_random();
`ifdef LOCK_VIOLATION_LOG_EN
      test_viol_log();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
